// File: rtl/apb_slave_regfile.sv
// APB completer with a register bank, wait states, PSLVERR and a read-only ID word.
// Optional byte-strobe writes are enabled by defining APB_SLV_PSTRB_EN.
module apb_slave_regfile #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h0001_F000,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 'hA5B0_0001
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] pstrb_i,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o,
    output logic [DATA_WIDTH-1:0]   ctrl_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

    localparam logic [9:0] LAST = 10'(NUM_REGS - 1);

    state_t                  state, nxt;
    logic [3:0]              cnt;
    logic [9:0]              lat_idx;
    logic                    lat_wr;
    logic                    lat_err;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [DATA_WIDTH-1:0]   regs [0:NUM_REGS-2];

    logic                    setup;
    logic [9:0]              dec_idx;
    logic                    dec_err;
    logic [9:0]              cur_idx;
    logic                    cur_wr;
    logic                    cur_err;
    logic [DATA_WIDTH-1:0]   rd_val;
    logic                    enter_rdy;
    logic                    leave;
    logic                    commit;

`ifdef APB_SLV_PSTRB_EN
    logic [DATA_WIDTH/8-1:0] lat_strb;
`else
    logic                    unused_strb;
    assign unused_strb = ^pstrb_i;
`endif

    assign setup   = psel_i & ~penable_i;
    assign dec_idx = paddr_i[11:2];

    // Address decode: window, alignment, range and ID-write checks
    always_comb begin
        dec_err = 1'b0;
        if (paddr_i[ADDR_WIDTH-1:12] != BASE_ADDR[ADDR_WIDTH-1:12]) dec_err = 1'b1;
        if (paddr_i[1:0] != 2'b00) dec_err = 1'b1;
        if (dec_idx > LAST) dec_err = 1'b1;
        if (pwrite_i && dec_idx == LAST) dec_err = 1'b1;
    end

    // Zero-wait transfers enter READY straight from IDLE, so use live decode there
    always_comb begin
        cur_idx = lat_idx;
        cur_wr  = lat_wr;
        cur_err = lat_err;
        if (state == S_IDLE) begin
            cur_idx = dec_idx;
            cur_wr  = pwrite_i;
            cur_err = dec_err;
        end
    end

    // Read mux; writes and errors return zero
    always_comb begin
        rd_val = '0;
        if (cur_idx == LAST) rd_val = ID_VALUE;
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (cur_idx == 10'(i)) rd_val = regs[i];
        end
        if (cur_wr || cur_err) rd_val = '0;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    // Next-state logic, including abort on dropped select
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: begin
                if (setup) nxt = (WAIT_CYCLES == 0) ? S_READY : S_WAIT;
            end
            S_WAIT: begin
                if (!psel_i)        nxt = S_IDLE;
                else if (cnt == '0) nxt = S_READY;
            end
            S_READY: begin
                if (!psel_i || penable_i) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        pready_o = (state == S_READY);
    end

    assign enter_rdy = (nxt == S_READY) && (state != S_READY);
    assign leave     = (nxt == S_IDLE) && (state != S_IDLE);
    assign commit    = (state == S_READY) && psel_i && penable_i && lat_wr && !lat_err;
    assign ctrl_o    = regs[0];

    // Latch the request at setup and count down wait states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            lat_idx   <= '0;
            lat_wr    <= 1'b0;
            lat_err   <= 1'b0;
            lat_wdata <= '0;
`ifdef APB_SLV_PSTRB_EN
            lat_strb  <= '0;
`endif
        end else if (state == S_IDLE && setup) begin
            cnt       <= 4'(WAIT_CYCLES - 1);
            lat_idx   <= dec_idx;
            lat_wr    <= pwrite_i;
            lat_err   <= dec_err;
            lat_wdata <= pwdata_i;
`ifdef APB_SLV_PSTRB_EN
            lat_strb  <= pstrb_i;
`endif
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Response registers load on entering READY and clear on leaving
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prdata_o  <= '0;
            pslverr_o <= 1'b0;
        end else if (enter_rdy) begin
            prdata_o  <= rd_val;
            pslverr_o <= cur_err;
        end else if (leave) begin
            prdata_o  <= '0;
            pslverr_o <= 1'b0;
        end
    end

    // Register bank write on completion of an error-free write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS - 1; i++) regs[i] <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (lat_idx == 10'(i)) begin
`ifdef APB_SLV_PSTRB_EN
                    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                        if (lat_strb[b]) regs[i][8*b +: 8] <= lat_wdata[8*b +: 8];
                    end
`else
                    regs[i] <= lat_wdata;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: one-wait and zero-wait instances.
// Table of transfers plus hand sequences for strobes, abort and stray enable.
module tb_apb_slave_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel0 = 1'b0;
    logic        psel1 = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata0, prdata1, ctrl0, ctrl1;
    logic        pready0, pready1, pslverr0, pslverr1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apb_slave_regfile #(.WAIT_CYCLES(1), .BASE_ADDR(32'h0001_F000)) u0 (
        .clk(clk), .rst_n(rst_n), .psel_i(psel0), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .prdata_o(prdata0), .pready_o(pready0), .pslverr_o(pslverr0), .ctrl_o(ctrl0)
    );

    apb_slave_regfile #(.WAIT_CYCLES(0), .BASE_ADDR(32'h0002_F000)) u1 (
        .clk(clk), .rst_n(rst_n), .psel_i(psel1), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .prdata_o(prdata1), .pready_o(pready1), .pslverr_o(pslverr1), .ctrl_o(ctrl1)
    );

    typedef struct {
        int          inst;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        logic [31:0] ctrl;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int inst);
        return inst == 1 ? pready1 : pready0;
    endfunction

    // One APB transfer; entered and left #1 after a rising edge
    task automatic apb(input int inst, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rd, output logic err, output int lat);
        psel0   = (inst == 0);
        psel1   = (inst == 1);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        pstrb   = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        paddr   = addr ^ 32'h4;
        pwdata  = ~wdata;
        lat     = 1;
        while (!rdy(inst) && lat <= 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rdy(inst)) chk("timeout", 32'(lat), 32'd0);
        rd  = inst == 1 ? prdata1 : prdata0;
        err = inst == 1 ? pslverr1 : pslverr0;
        @(posedge clk); #1;
        psel0   = 1'b0;
        psel1   = 1'b0;
        penable = 1'b0;
        chk("ready_clear", {31'd0, rdy(inst)}, 32'd0);
        chk("prdata_clear", inst == 1 ? prdata1 : prdata0, 32'd0);
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat;
    logic [31:0] exp_v;

    initial begin
        vt[0]  = '{0, 1'b0, 32'h0001_F000, 32'h0,         32'h0,         1'b0, 32'h0};
        vt[1]  = '{0, 1'b1, 32'h0001_F000, 32'hDEAD_BEEF, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vt[2]  = '{0, 1'b0, 32'h0001_F000, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        vt[3]  = '{0, 1'b0, 32'h0001_F03C, 32'h0,         32'hA5B0_0001, 1'b0, 32'hDEAD_BEEF};
        vt[4]  = '{0, 1'b1, 32'h0001_F03C, 32'h1234,      32'h0,         1'b1, 32'hDEAD_BEEF};
        vt[5]  = '{0, 1'b0, 32'h0001_F03C, 32'h0,         32'hA5B0_0001, 1'b0, 32'hDEAD_BEEF};
        vt[6]  = '{0, 1'b1, 32'h0001_F040, 32'h55,        32'h0,         1'b1, 32'hDEAD_BEEF};
        vt[7]  = '{0, 1'b1, 32'h0001_F002, 32'h66,        32'h0,         1'b1, 32'hDEAD_BEEF};
        vt[8]  = '{0, 1'b1, 32'h0003_F000, 32'h77,        32'h0,         1'b1, 32'hDEAD_BEEF};
        vt[9]  = '{0, 1'b0, 32'h0001_F040, 32'h0,         32'h0,         1'b1, 32'hDEAD_BEEF};
        vt[10] = '{0, 1'b0, 32'h0001_F002, 32'h0,         32'h0,         1'b1, 32'hDEAD_BEEF};
        vt[11] = '{0, 1'b0, 32'h0003_F000, 32'h0,         32'h0,         1'b1, 32'hDEAD_BEEF};
        vt[12] = '{0, 1'b0, 32'h0001_F000, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        vt[13] = '{0, 1'b1, 32'h0001_F004, 32'hCAFE_F00D, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vt[14] = '{0, 1'b0, 32'h0001_F004, 32'h0,         32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF};
        vt[15] = '{1, 1'b1, 32'h0002_F004, 32'h0BAD_CAFE, 32'h0,         1'b0, 32'h0};
        vt[16] = '{1, 1'b0, 32'h0002_F004, 32'h0,         32'h0BAD_CAFE, 1'b0, 32'h0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pready0", {31'd0, pready0}, 32'd0);
        chk("rst_pslverr0", {31'd0, pslverr0}, 32'd0);
        chk("rst_prdata0", prdata0, 32'd0);
        chk("rst_ctrl0", ctrl0, 32'd0);
        chk("rst_pready1", {31'd0, pready1}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            apb(vt[i].inst, vt[i].wr, vt[i].addr, vt[i].wdata, 4'hF, rd, err, lat);
            chk($sformatf("v%0d_rdata", i), rd, vt[i].rd);
            chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vt[i].err});
            chk($sformatf("v%0d_lat", i), 32'(lat), vt[i].inst == 1 ? 32'd1 : 32'd2);
            chk($sformatf("v%0d_ctrl", i), vt[i].inst == 1 ? ctrl1 : ctrl0, vt[i].ctrl);
        end

        apb(1, 1'b0, 32'h0001_F004, 32'h0, 4'hF, rd, err, lat);
        chk("inst1_wrong_base_err", {31'd0, err}, 32'd1);
        chk("inst1_wrong_base_rd", rd, 32'd0);

        apb(0, 1'b1, 32'h0001_F008, 32'h1111_1111, 4'hF, rd, err, lat);
        apb(0, 1'b1, 32'h0001_F008, 32'hAABB_CCDD, 4'b0101, rd, err, lat);
        apb(0, 1'b0, 32'h0001_F008, 32'h0, 4'hF, rd, err, lat);
`ifdef APB_SLV_PSTRB_EN
        exp_v = 32'h11BB_11DD;
`else
        exp_v = 32'hAABB_CCDD;
`endif
        chk("strb_merge", rd, exp_v);

        apb(0, 1'b1, 32'h0001_F008, 32'h9999_9999, 4'b0000, rd, err, lat);
        chk("strb_zero_err", {31'd0, err}, 32'd0);
        apb(0, 1'b0, 32'h0001_F008, 32'h0, 4'hF, rd, err, lat);
`ifndef APB_SLV_PSTRB_EN
        exp_v = 32'h9999_9999;
`endif
        chk("strb_zero_rd", rd, exp_v);

        psel0   = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h0001_F008;
        pwdata  = 32'h1234_5678;
        pstrb   = 4'hF;
        @(posedge clk); #1;
        psel0 = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready", {31'd0, pready0}, 32'd0);
        @(posedge clk); #1;
        chk("abort_ready2", {31'd0, pready0}, 32'd0);
        apb(0, 1'b0, 32'h0001_F008, 32'h0, 4'hF, rd, err, lat);
        chk("abort_no_write", rd, exp_v);
        chk("abort_next_lat", 32'(lat), 32'd2);

        psel0   = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = 32'h0001_F000;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stray_en_%0d", k), {31'd0, pready0}, 32'd0);
        end
        psel0   = 1'b0;
        penable = 1'b0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
